// File: rtl/img2col_window_ctrl.sv
// Sliding-window controller: builds K x K windows from K-pixel columns, reusing K-STRIDE columns between windows.
// Optional feature: define IMG2COL_STALL_CNT_EN to add the 32-bit stall_cnt output.
module img2col_window_ctrl #(
    parameter int DATA_W = 16,
    parameter int K      = 5,
    parameter int STRIDE = 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [15:0]           num_win,
    input  logic                  flush,
    input  logic                  col_valid,
    output logic                  col_ready,
    input  logic [K*DATA_W-1:0]   col_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [K*K*DATA_W-1:0] win_data,
    output logic [15:0]           win_idx,
    output logic                  busy,
    output logic                  done
`ifdef IMG2COL_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);
    localparam int CNT_W = $clog2(K + 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] SLIDE_LAST = CNT_W'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, SLIDE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  col_cnt;
    logic [15:0]       num_win_q;
    logic [DATA_W-1:0] win_q [K][K];
    logic              col_take;
    logic              win_take;

    // Handshake strobes depend on registered state only, never on inputs.
    assign col_ready = (state == FILL) || (state == SLIDE);
    assign win_valid = (state == EMIT);
    assign busy      = (state != IDLE);
    assign col_take  = col_valid && col_ready;
    assign win_take  = win_valid && win_ready;

    always_comb begin
        win_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_data[(r*K + c)*DATA_W +: DATA_W] = win_q[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            col_cnt   <= '0;
            num_win_q <= '0;
            win_idx   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                col_cnt <= '0;
                win_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (num_win == 16'd0) begin
                                done <= 1'b1;
                            end else begin
                                state     <= FILL;
                                col_cnt   <= '0;
                                win_idx   <= '0;
                                num_win_q <= num_win;
                            end
                        end
                    end
                    FILL: begin
                        if (col_take) begin
                            col_cnt <= col_cnt + 1'b1;
                            if (col_cnt == FILL_LAST) state <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (win_take) begin
                            if (win_idx == num_win_q - 16'd1) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state   <= SLIDE;
                                win_idx <= win_idx + 16'd1;
                                col_cnt <= '0;
                            end
                        end
                    end
                    SLIDE: begin
                        if (col_take) begin
                            col_cnt <= col_cnt + 1'b1;
                            if (col_cnt == SLIDE_LAST) state <= EMIT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Column c takes column c+1; the newest column enters at K-1. A flushed column is not consumed.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else if (col_take && !flush) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_q[r][c] <= win_q[r][c+1];
                end
                win_q[r][K-1] <= col_data[r*DATA_W +: DATA_W];
            end
        end
    end

`ifdef IMG2COL_STALL_CNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stall_cnt <= '0;
        end else if (start && state == IDLE) begin
            stall_cnt <= '0;
        end else if (win_valid && !win_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
